// File: rtl/aes_cipher_sched_if.sv
// Requester/response bus shared between the crypto clients and the
// AES cipher scheduler.
//
// Signals:
//   req_valid[NREQ]        : job request, one bit per requester
//   req_ready[NREQ]        : job accepted (one-hot or zero)
//   req_pt[NREQ][128]      : per-requester plaintext
//   req_ksel[NREQ][KSEL_W] : per-requester key-slot select
//   rsp_valid              : response available
//   rsp_ready              : response consumer ready
//   rsp_id[ID_W]           : index of the requester owning the response
//   rsp_ct[128]            : ciphertext (0 on timeout abort)
//   rsp_err                : job aborted on timeout
//
// Modports:
//   slave  : the scheduler side
//   master : the client side (requesters plus response consumer)
interface aes_cipher_sched_if #(
    parameter int NREQ   = 4,
    parameter int KSEL_W = 2,
    parameter int ID_W   = $clog2(NREQ)
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][127:0]      req_pt;
    logic [NREQ-1:0][KSEL_W-1:0] req_ksel;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [ID_W-1:0]             rsp_id;
    logic [127:0]                rsp_ct;
    logic                        rsp_err;

    modport slave (
        input  req_valid, req_pt, req_ksel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_ct, rsp_err
    );

    modport master (
        output req_valid, req_pt, req_ksel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_ct, rsp_err
    );
endinterface

// File: rtl/aes_cipher_sched.sv
// Round-robin scheduler sharing one iterative AES cipher core among NREQ
// requesters. One job is in flight at a time: IDLE grants a requester,
// RUN holds core_load high until the core reports done (or a timeout
// expires), RESP presents the tagged ciphertext until it is consumed.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : requester/response bus (slave modport)
//   core_load   : core run enable; low clears the core's round counter
//   core_pt     : plaintext to the core (stable through RUN and RESP)
//   core_ksel   : key-slot select to the key-schedule store
//   core_ct     : ciphertext from the core
//   core_valid  : core done strobe; ignored outside RUN
//   busy        : high in RUN or RESP
module aes_cipher_sched #(
    parameter int NREQ    = 4,
    parameter int Nk      = 4,
    parameter int Nr      = Nk + 6,
    parameter int KSEL_W  = 2,
    parameter int TIMEOUT = Nr + 4,
    parameter int ID_W    = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_cipher_sched_if.slave  bus,
    output logic               core_load,
    output logic [127:0]       core_pt,
    output logic [KSEL_W-1:0]  core_ksel,
    input  logic [127:0]       core_ct,
    input  logic               core_valid,
    output logic               busy
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [127:0]        pt_q, pt_d;
    logic [KSEL_W-1:0]   ksel_q, ksel_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [127:0]        ct_q, ct_d;
    logic                err_q, err_d;

    logic                grant_any;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     cand;

    // Round-robin search starting one past the last grant, so the most
    // recently served requester has lowest priority. Modulo arithmetic
    // keeps the search correct when NREQ is not a power of two.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % NREQ);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // The accept strobe is combinational so the grant lands in the same
    // IDLE cycle; it is masked by rst_n so nothing is acknowledged while
    // the scheduler is held in reset.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && (state_q == ST_IDLE) && grant_any) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state logic. The RUN counter only ever counts up to TIMEOUT,
    // since reaching it forces the exit to RESP; a core_valid in the same
    // cycle as the timeout wins, because the result is genuine.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        pt_d    = pt_q;
        ksel_d  = ksel_q;
        id_d    = id_q;
        ct_d    = ct_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    ptr_d   = grant_idx;
                    id_d    = grant_idx;
                    pt_d    = bus.req_pt[grant_idx];
                    ksel_d  = bus.req_ksel[grant_idx];
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_valid) begin
                    ct_d    = core_ct;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    ct_d    = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers. Reset drops any in-flight job and
    // points the arbiter at NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= ID_W'(NREQ - 1);
            cnt_q   <= '0;
            pt_q    <= '0;
            ksel_q  <= '0;
            id_q    <= '0;
            ct_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            pt_q    <= pt_d;
            ksel_q  <= ksel_d;
            id_q    <= id_d;
            ct_q    <= ct_d;
            err_q   <= err_d;
        end
    end

    assign core_load     = (state_q == ST_RUN);
    assign busy          = (state_q != ST_IDLE);
    assign core_pt       = pt_q;
    assign core_ksel     = ksel_q;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_ct    = ct_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: doc/aes_cipher_sched.md
# aes_cipher_sched

Round-robin scheduler that shares one iterative AES cipher core among `NREQ` requesters. It accepts one plaintext job at a time over per-requester valid/ready handshakes and drives the core's `load`/plaintext/key-slot inputs. It returns the ciphertext tagged with the requester index on a single response channel with backpressure. It sits between the crypto clients and the cipher core plus its key-schedule store; `core_ksel` selects the expanded key schedule presented to the core.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `Nk`, 4: key length in 32-bit words (4/6/8).
- `Nr`, `Nk+6`: number of rounds.
- `KSEL_W`, 2: width of the key-slot select.
- `TIMEOUT`, `Nr+4`: maximum RUN cycles to wait for `core_valid` before aborting.
- `ID_W`, `$clog2(NREQ)`: requester index width.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in `NREQ`: job request, one bit per requester.
- `req_ready` out `NREQ`: job accepted, one-hot or zero.
- `req_pt` in `NREQ`x128: per-requester plaintext.
- `req_ksel` in `NREQ`x`KSEL_W`: per-requester key slot.
- `core_load` out 1: core run enable; the core clears its round counter while this is low.
- `core_pt` out 128: plaintext to the core.
- `core_ksel` out `KSEL_W`: key-slot select to the key-schedule store.
- `core_ct` in 128: core ciphertext.
- `core_valid` in 1: core done; rises `Nr+1` edges after `core_load` rises.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumer ready.
- `rsp_id` out `ID_W`: index of the requester that owns the response.
- `rsp_ct` out 128: ciphertext.
- `rsp_err` out 1: job aborted on timeout; `rsp_ct` is 0.
- `busy` out 1: high in RUN or RESP.

## Operation
- FSM states:
  - IDLE: if any `req_valid` is high, grant round-robin, assert `req_ready[g]`, register `req_pt[g]`, `req_ksel[g]` and `g`, then go to RUN.
  - RUN: `core_load` is 1. On `core_valid`, capture `core_ct`, clear `rsp_err`, go to RESP. If the cycle counter reaches `TIMEOUT` first, set `rsp_err`=1 and `rsp_ct`=0, go to RESP.
  - RESP: `core_load` is 0 and `rsp_valid` is 1. On `rsp_valid & rsp_ready`, go to IDLE.
- Round-robin arbitration:
  - The last-grant pointer resets to `NREQ-1`, so requester 0 has first priority.
  - Search order is pointer+1, wrapping modulo `NREQ`.
  - The pointer updates only on a grant.
- `req_ready` is combinational: `(state==IDLE) & req_valid[g]`, one-hot. It is never asserted outside IDLE.
- Requesters hold `req_valid`/`req_pt`/`req_ksel` stable until `req_ready`. A requester that is not granted waits, and at most `NREQ-1` other jobs are served before it (fairness bound).
- `core_pt`/`core_ksel` are registered and stay stable for the whole RUN and RESP.
- `rsp_id`/`rsp_ct`/`rsp_err` are stable while `rsp_valid`=1 and `rsp_ready`=0.
- `core_valid` seen outside RUN is ignored.
- The RUN cycle counter clears on entry to RUN and saturates at `TIMEOUT`.
- Reset, asynchronous and taking effect at any point including mid-RUN or mid-RESP:
  - state IDLE, pointer `NREQ-1`.
  - Outputs: `core_load`=0, `core_pt`=0, `core_ksel`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_ct`=0, `rsp_err`=0, `busy`=0, `req_ready`=0.
  - An in-flight job is dropped and no response is issued.

## Timing
- Accept at cycle c (the IDLE cycle with `req_ready` high).
- RUN spans c+1..c+Nr+2. `core_load` rises at c+1, and `core_valid` is first seen at c+Nr+2.
- `rsp_valid` rises at c+Nr+3. With `rsp_ready`=1 the FSM returns to IDLE at c+Nr+4, and the next accept can occur in that cycle.
- Minimum job period is `Nr+4` cycles: 14 for Nk=4, 16 for Nk=6, 18 for Nk=8.
- `core_load` is low for at least 2 cycles between jobs (RESP + IDLE), which guarantees the core's counter clears.
- Timeout: with no `core_valid`, `rsp_valid` rises at c+`TIMEOUT`+2 with `rsp_err`=1.
- Simultaneous requests in IDLE produce exactly one grant per IDLE cycle.
- A `rsp_ready` stall holds the FSM in RESP indefinitely; new requests remain unaccepted (`req_ready`=0).

## Test plan
- Single job, Nk=4, FIPS-197 vector:
  - Stimulus: requester 2, slot holding key 000102…0f, pt 00112233445566778899aabbccddeeff.
  - Required response: `rsp_ct`=69c4e0d86a7b0430d8cdb78070b4c55a, `rsp_id`=2, `rsp_err`=0, `rsp_valid` exactly 13 cycles after accept.
- All four requesters asserted continuously from reset:
  - Required grant order 0,1,2,3,0, with accepts 14 cycles apart and `rsp_id` matching each grant.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 20 cycles during RESP.
  - Required response: `rsp_ct`/`rsp_id` stable, `req_ready` stays 0, `core_load` stays 0; the next accept occurs the cycle after the handshake.
- Core model never raises `core_valid`:
  - Required response: `rsp_valid` at accept+16 (Nk=4) with `rsp_err`=1 and `rsp_ct`=0, and the scheduler then serves the next request normally.
- `rst_n` pulsed low mid-RUN (accept+5):
  - Required response: all outputs go to reset values asynchronously, and no response is issued for that job.
  - After release, requester 0 wins over simultaneous requester 3.
- Nk=8 build with FIPS-197 AES-256 vector (key 000102…1f):
  - Required response: `rsp_ct`=8ea2b7ca516745bfeafc49904b496089 at accept+17.
